traffic_ctrl_2way: RTL and testbench

- Parametrised two-direction (A = main road, B = side road) intersection traffic-light controller with per-phase programmable durations and a one-second timebase enable.
- Two-digit 7-segment countdown of the remaining time, a stop (all-red hold) input and a night (flashing yellow) mode.
- Sits between the board tick generator and the lamp/7-seg pins.

---
 rtl/traffic_pkg.sv | 43 ++++
 rtl/traffic_ctrl_2way_if.sv | 22 ++
 rtl/traffic_ctrl_2way_seg7_dec.sv | 32 +++
 rtl/traffic_ctrl_2way.sv | 139 +++++++++++++
 tb/tb_traffic_ctrl_2way.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-way intersection controller:
// state encodings, direction flags, 7-segment codes and the lamp decoder.
package traffic_pkg;

  typedef enum logic [2:0] {
    A_GRN   = 3'd0,
    A_YEL   = 3'd1,
    ALL_RED = 3'd2,
    B_GRN   = 3'd3,
    B_YEL   = 3'd4,
    HOLD    = 3'd5,
    FLASH   = 3'd6
  } state_t;

  localparam logic DIR_A = 1'b0;
  localparam logic DIR_B = 1'b1;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Lamp vector order: {a_g, a_y, a_r, b_g, b_y, b_r}; unknown codes show both reds.
  function automatic logic [5:0] lamps_of(input state_t s, input logic flash);
    case (s)
      A_GRN:   lamps_of = 6'b100_001;
      A_YEL:   lamps_of = 6'b010_001;
      B_GRN:   lamps_of = 6'b001_100;
      B_YEL:   lamps_of = 6'b001_010;
      FLASH:   lamps_of = {1'b0, flash, 1'b0, 1'b0, flash, 1'b0};
      default: lamps_of = 6'b001_001;
    endcase
  endfunction

endpackage

// File: rtl/traffic_ctrl_2way_if.sv
// Control inputs and lamp/display outputs of the intersection controller.
interface traffic_ctrl_2way_if #(parameter int CW = 7);
  logic          tick;
  logic          stop;
  logic          night;
  logic          a_g, a_y, a_r;
  logic          b_g, b_y, b_r;
  logic [CW-1:0] cnt;
  logic [7:0]    HEX0;
  logic [7:0]    HEX1;
  logic [2:0]    c;

  modport master (
    output tick, stop, night,
    input  a_g, a_y, a_r, b_g, b_y, b_r, cnt, HEX0, HEX1, c
  );

  modport slave (
    input  tick, stop, night,
    output a_g, a_y, a_r, b_g, b_y, b_r, cnt, HEX0, HEX1, c
  );
endinterface

// File: rtl/traffic_ctrl_2way_seg7_dec.sv
// One 7-segment digit: BCD value plus blank flag to an active-low pattern (dp off).
module seg7_dec
  import traffic_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] seg
);

  // Digit lookup; non-decimal values show blank.
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/traffic_ctrl_2way.sv
// Two-direction traffic-light controller with tick-driven phase timer,
// stop (all-red hold), night (flashing yellow) and a two-digit countdown.
module traffic_ctrl_2way
  import traffic_pkg::*;
#(
  parameter int GREEN_T   = 8,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 2,
  parameter int CW        = 7
) (
  input logic                ck,
  input logic                rs,
  traffic_ctrl_2way_if.slave io
);

  localparam logic [CW-1:0] G_LD  = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] Y_LD  = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] AR_LD = CW'(ALL_RED_T - 1);

  state_t        state_r, nxt_state_s, disp_state_s;
  logic [CW-1:0] cnt_r, nxt_cnt_s, disp_cnt_s;
  logic          dir_r, nxt_dir_s;
  logic          flash_r, nxt_flash_s;
  logic [5:0]    lamps_r;
  logic [7:0]    hex0_r, hex1_r;
  logic [CW-1:0] tens_s, ones_s;
  logic [7:0]    seg0_s, seg1_s;

  // Next phase/timer: stop beats night beats the timer.
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    nxt_dir_s   = dir_r;
    nxt_flash_s = flash_r;
    if (io.stop) begin
      nxt_state_s = HOLD;
    end else if (io.night) begin
      nxt_state_s = FLASH;
      nxt_cnt_s   = '0;
      if (state_r != FLASH) begin
        nxt_flash_s = 1'b0;
      end else if (io.tick) begin
        nxt_flash_s = ~flash_r;
      end else begin
        nxt_flash_s = flash_r;
      end
    end else begin
      case (state_r)
        HOLD, FLASH: begin
          nxt_state_s = ALL_RED;
          nxt_cnt_s   = AR_LD;
        end
        A_GRN, A_YEL, ALL_RED, B_GRN, B_YEL: begin
          if (!io.tick) begin
            nxt_cnt_s = cnt_r;
          end else if (cnt_r != '0) begin
            nxt_cnt_s = cnt_r - CW'(1);
          end else begin
            case (state_r)
              A_GRN: begin nxt_state_s = A_YEL;   nxt_cnt_s = Y_LD;  end
              B_GRN: begin nxt_state_s = B_YEL;   nxt_cnt_s = Y_LD;  end
              A_YEL: begin nxt_state_s = ALL_RED; nxt_cnt_s = AR_LD; end
              B_YEL: begin nxt_state_s = ALL_RED; nxt_cnt_s = AR_LD; end
              ALL_RED: begin
                // Clearance hands over to the road that did not have the last green.
                nxt_cnt_s = G_LD;
                if (dir_r == DIR_A) begin
                  nxt_state_s = B_GRN;
                  nxt_dir_s   = DIR_B;
                end else begin
                  nxt_state_s = A_GRN;
                  nxt_dir_s   = DIR_A;
                end
              end
              default: begin nxt_state_s = ALL_RED; nxt_cnt_s = AR_LD; end
            endcase
          end
        end
        default: begin
          nxt_state_s = ALL_RED;
          nxt_cnt_s   = AR_LD;
        end
      endcase
    end
  end

  // Display source follows the value the counter takes at this edge.
  always_comb begin
    disp_state_s = nxt_state_s;
    disp_cnt_s   = nxt_cnt_s;
    if (rs) begin
      disp_state_s = A_GRN;
      disp_cnt_s   = G_LD;
    end else begin
      disp_state_s = nxt_state_s;
      disp_cnt_s   = nxt_cnt_s;
    end
    tens_s = disp_cnt_s / CW'(10);
    ones_s = disp_cnt_s % CW'(10);
  end

  seg7_dec u_ones (
    .digit (4'(ones_s)),
    .blank (disp_state_s == FLASH),
    .seg   (seg0_s)
  );

  seg7_dec u_tens (
    .digit (4'(tens_s)),
    .blank ((tens_s == '0) || (disp_state_s == FLASH) || (disp_state_s == HOLD)),
    .seg   (seg1_s)
  );

  // State, timer, lamps and digits all update together on the clock edge.
  always_ff @(posedge ck) begin
    if (rs) begin
      state_r <= A_GRN;
      cnt_r   <= G_LD;
      dir_r   <= DIR_A;
      flash_r <= 1'b0;
      lamps_r <= lamps_of(A_GRN, 1'b0);
    end else begin
      state_r <= nxt_state_s;
      cnt_r   <= nxt_cnt_s;
      dir_r   <= nxt_dir_s;
      flash_r <= nxt_flash_s;
      lamps_r <= lamps_of(nxt_state_s, nxt_flash_s);
    end
    hex0_r <= (disp_state_s == HOLD) ? SEG_DASH : seg0_s;
    hex1_r <= seg1_s;
  end

  assign {io.a_g, io.a_y, io.a_r, io.b_g, io.b_y, io.b_r} = lamps_r;
  assign io.cnt  = cnt_r;
  assign io.HEX0 = hex0_r;
  assign io.HEX1 = hex1_r;
  assign io.c    = state_r;

endmodule

// File: tb/tb_traffic_ctrl_2way.sv
// Bench for traffic_ctrl_2way: directed scenarios plus random traffic, checked
// every cycle against a schedule-table model of the intersection.
module tb_traffic_ctrl_2way;
  import traffic_pkg::*;

  localparam int CW = 7;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic rs, rs2;
  traffic_ctrl_2way_if #(.CW(CW)) io1 ();
  traffic_ctrl_2way_if #(.CW(CW)) io2 ();

  traffic_ctrl_2way #(.GREEN_T(5), .YELLOW_T(2), .ALL_RED_T(1), .CW(CW)) dut1 (
    .ck(ck), .rs(rs), .io(io1.slave));
  traffic_ctrl_2way #(.GREEN_T(25), .YELLOW_T(2), .ALL_RED_T(1), .CW(CW)) dut2 (
    .ck(ck), .rs(rs2), .io(io2.slave));

  int tests = 0;
  int fails = 0;

  // Model: mode 0 = normal cycle, 1 = all-red hold, 2 = flashing.
  // idx walks the six-slot schedule A_GRN A_YEL AR B_GRN B_YEL AR.
  int m_mode [2];
  int m_idx  [2];
  int m_rem  [2];
  bit m_lastb[2];
  bit m_flash[2];
  bit chk_en [2];
  int dur    [2][6];

  logic [7:0] segtab  [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [5:0] lamptab [6]  = '{6'b100001, 6'b010001, 6'b001001, 6'b001100, 6'b001010, 6'b001001};
  logic [2:0] ctab    [6]  = '{A_GRN, A_YEL, ALL_RED, B_GRN, B_YEL, ALL_RED};

  bit r_rs, r_stop, r_night, r_tick, r_rs2, r_tick2;
  int phase_cnt = 0;

  task automatic mstep(input int k, input bit r, input bit s, input bit n, input bit t);
    if (r) begin
      m_mode[k] = 0; m_idx[k] = 0; m_rem[k] = dur[k][0] - 1;
      m_lastb[k] = 1'b0; m_flash[k] = 1'b0; chk_en[k] = 1'b1;
    end else if (s) begin
      m_mode[k] = 1;
    end else if (n) begin
      if (m_mode[k] != 2) begin
        m_mode[k] = 2; m_flash[k] = 1'b0; m_rem[k] = 0;
      end else if (t) begin
        m_flash[k] = !m_flash[k];
      end
    end else if (m_mode[k] != 0) begin
      m_mode[k] = 0;
      m_idx[k]  = m_lastb[k] ? 5 : 2;
      m_rem[k]  = dur[k][2] - 1;
    end else if (t) begin
      if (m_rem[k] > 0) begin
        m_rem[k]--;
      end else begin
        m_idx[k] = (m_idx[k] + 1) % 6;
        m_rem[k] = dur[k][m_idx[k]] - 1;
        if (m_idx[k] == 0) m_lastb[k] = 1'b0;
        if (m_idx[k] == 3) m_lastb[k] = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] expv(input int k);
    logic [5:0] l;
    logic [2:0] cc;
    logic [6:0] cn;
    logic [7:0] h0, h1;
    if (m_mode[k] == 1) begin
      l = 6'b001001; cc = HOLD; cn = 7'(m_rem[k]); h0 = 8'hBF; h1 = 8'hFF;
    end else if (m_mode[k] == 2) begin
      l = {1'b0, m_flash[k], 1'b0, 1'b0, m_flash[k], 1'b0};
      cc = FLASH; cn = 7'd0; h0 = 8'hFF; h1 = 8'hFF;
    end else begin
      l = lamptab[m_idx[k]]; cc = ctab[m_idx[k]]; cn = 7'(m_rem[k]);
      h0 = segtab[m_rem[k] % 10];
      h1 = (m_rem[k] / 10 == 0) ? 8'hFF : segtab[m_rem[k] / 10];
    end
    return {l, cc, cn, h0, h1};
  endfunction

  function automatic logic [31:0] actv(input int k);
    if (k == 0)
      return {io1.a_g, io1.a_y, io1.a_r, io1.b_g, io1.b_y, io1.b_r, io1.c, io1.cnt, io1.HEX0, io1.HEX1};
    else
      return {io2.a_g, io2.a_y, io2.a_r, io2.b_g, io2.b_y, io2.b_r, io2.c, io2.cnt, io2.HEX0, io2.HEX1};
  endfunction

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge ck) begin
    for (int k = 0; k < 2; k++) begin
      if (chk_en[k]) begin
        tests++;
        if (actv(k) !== expv(k)) begin
          fails++;
          $display("FAIL model_cmp dut%0d t=%0t got=%h exp=%h (lamps6,c3,cnt7,hex0,hex1)",
                   k + 1, $time, actv(k), expv(k));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge ck);
    rs = r_rs; rs2 = r_rs2;
    io1.tick = r_tick; io1.stop = r_stop; io1.night = r_night;
    io2.tick = r_tick2; io2.stop = 1'b0; io2.night = 1'b0;
    @(posedge ck);
    mstep(0, r_rs, r_stop, r_night, r_tick);
    mstep(1, r_rs2, 1'b0, 1'b0, r_tick2);
    #1;
  endtask

  task automatic tstep();
    r_tick = (phase_cnt % 4 == 3);
    phase_cnt++;
    step();
  endtask

  task automatic run_until(input int idx, input int rem);
    bit ok;
    for (int i = 0; i < 400; i++) begin
      if (m_mode[0] == 0 && m_idx[0] == idx && m_rem[0] == rem) break;
      tstep();
    end
    ok = (m_mode[0] == 0 && m_idx[0] == idx && m_rem[0] == rem);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL run_until idx=%0d rem=%0d got idx=%0d rem=%0d", idx, rem, m_idx[0], m_rem[0]);
    end
    r_tick = 1'b0;
  endtask

  initial begin
    dur[0] = '{5, 2, 1, 5, 2, 1};
    dur[1] = '{25, 2, 1, 25, 2, 1};
    chk_en = '{1'b0, 1'b0};
    r_stop = 1'b0; r_night = 1'b0; r_tick = 1'b0; r_tick2 = 1'b0;

    // 1: reset and one full cycle plus four ticks
    r_rs = 1'b1; r_rs2 = 1'b1; step();
    r_rs = 1'b0; r_rs2 = 1'b0;
    chk("s1_rst_cnt", 32'(io1.cnt), 32'd4);
    chk("s1_rst_hex0", 32'(io1.HEX0), 32'h99);
    chk("s1_rst_hex1", 32'(io1.HEX1), 32'hFF);
    chk("s1_rst_lamps", 32'({io1.a_g, io1.a_y, io1.a_r, io1.b_g, io1.b_y, io1.b_r}), 32'b100001);
    for (int i = 0; i < 80; i++) tstep();
    r_tick = 1'b0;
    chk("s1_after20_cnt", 32'(io1.cnt), 32'd0);
    chk("s1_after20_ag", 32'(io1.a_g), 32'd1);

    // 2: stop in B_GRN at cnt=2
    run_until(3, 2);
    r_stop = 1'b1; r_tick = 1'b0; step();
    chk("s2_hold_c", 32'(io1.c), 32'(HOLD));
    chk("s2_hold_hex0", 32'(io1.HEX0), 32'hBF);
    chk("s2_hold_cnt", 32'(io1.cnt), 32'd2);
    for (int i = 0; i < 8; i++) tstep();
    r_stop = 1'b0; r_tick = 1'b0; step();
    chk("s2_rel_c", 32'(io1.c), 32'(ALL_RED));
    r_tick = 1'b1; step(); r_tick = 1'b0;
    chk("s2_agrn_cnt", 32'(io1.cnt), 32'd4);
    chk("s2_agrn_ag", 32'(io1.a_g), 32'd1);

    // 3: night in A_YEL
    run_until(1, 1);
    r_night = 1'b1; step();
    chk("s3_flash_c", 32'(io1.c), 32'(FLASH));
    chk("s3_flash_ay0", 32'({io1.a_y, io1.b_y, io1.a_r, io1.b_r}), 32'b0000);
    chk("s3_flash_hex", 32'({io1.HEX1, io1.HEX0}), 32'hFFFF);
    r_tick = 1'b1; step(); r_tick = 1'b0;
    chk("s3_flash_ay1", 32'({io1.a_y, io1.b_y, io1.a_r, io1.b_r}), 32'b1100);
    for (int i = 0; i < 8; i++) tstep();
    r_night = 1'b0; r_tick = 1'b0; step();
    chk("s3_rel_c", 32'(io1.c), 32'(ALL_RED));
    r_tick = 1'b1; step(); r_tick = 1'b0;
    chk("s3_bgrn", 32'({io1.b_g, io1.a_r}), 32'b11);

    // 4: stop on the final tick of A_GRN, then stop+night, then night only
    run_until(0, 0);
    r_stop = 1'b1; r_tick = 1'b1; step(); r_tick = 1'b0;
    chk("s4_hold_not_yel", 32'(io1.c), 32'(HOLD));
    r_night = 1'b1; step();
    chk("s4_both_hold", 32'(io1.c), 32'(HOLD));
    r_stop = 1'b0; step();
    chk("s4_flash", 32'(io1.c), 32'(FLASH));
    r_night = 1'b0; step();

    // 5: reset mid-B_YEL
    run_until(4, 1);
    r_rs = 1'b1; step(); r_rs = 1'b0;
    chk("s5_rst_c", 32'(io1.c), 32'(A_GRN));
    chk("s5_rst_cnt", 32'(io1.cnt), 32'd4);
    chk("s5_rst_lamps", 32'({io1.a_g, io1.a_y, io1.a_r, io1.b_g, io1.b_y, io1.b_r}), 32'b100001);

    // 6: GREEN_T=25 display
    r_rs2 = 1'b1; step(); r_rs2 = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("s6_cnt24", 32'(io2.cnt), 32'd24);
    chk("s6_hex24", 32'({io2.HEX1, io2.HEX0}), 32'hA499);
    for (int i = 0; i < 60; i++) begin
      r_tick2 = (i % 4 == 3);
      step();
    end
    r_tick2 = 1'b0;
    chk("s6_cnt9", 32'(io2.cnt), 32'd9);
    chk("s6_hex9", 32'({io2.HEX1, io2.HEX0}), 32'hFF90);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r_tick  = ($urandom_range(0, 3) == 0);
      r_tick2 = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) r_stop = !r_stop;
      if ($urandom_range(0, 29) == 0) r_night = !r_night;
      r_rs  = ($urandom_range(0, 299) == 0);
      r_rs2 = ($urandom_range(0, 399) == 0);
      step();
    end

    @(negedge ck);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
